// File: rtl/key_sw_pkg.sv
// Shared constants for the KEY/SW capture slave: register word addresses
// and the default debounce interval.
package key_sw_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_MASK     = 2'd1;
    localparam logic [1:0] ADDR_CAPTURE  = 2'd2;
    localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;

    // 20 ms of stable input at a 50 MHz system clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/key_sw_capture_debounce_bit.sv
// One board input: two-flop synchroniser, debounce counter, accepted level,
// the first-acceptance (valid) flag and a one-clock pulse for every accepted
// change that happens after the bit became valid.
module debounce_bit
    import key_sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic debounced,
    output logic accepted
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic             valid;
    logic [CNT_W-1:0] diff_cnt;
    logic [CNT_W-1:0] stable_cnt;
    logic             differs;
    logic             diff_done;
    logic             stable_done;

    assign differs     = sync_q ^ debounced;
    assign diff_done   = differs && (diff_cnt == LAST_COUNT);
    assign stable_done = !differs && !valid && (stable_cnt == LAST_COUNT);

    // Two-flop synchroniser bringing the asynchronous pin into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
        end
    end

    // Count clocks of disagreement; flip the accepted level once it has lasted long enough
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_cnt  <= '0;
            debounced <= 1'b0;
        end else if (!differs) begin
            diff_cnt <= '0;
        end else if (diff_done) begin
            diff_cnt  <= '0;
            debounced <= ~debounced;
        end else begin
            diff_cnt <= diff_cnt + 1'b1;
        end
    end

    // Before the bit is valid, count clocks it sits unchanged at its reset level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
        end else if (differs || valid || stable_done) begin
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    // Valid latches on first acceptance; only later changes are reported as edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            accepted <= 1'b0;
        end else begin
            accepted <= diff_done && valid;
            if (diff_done || stable_done) begin
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_sw_capture.sv
// Avalon-MM slave bringing debounced KEY/SW inputs into the HPS, with a
// write-1-to-clear edge capture register and a masked level interrupt.
module key_sw_capture
    import key_sw_pkg::*;
#(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_raw,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    output logic [WIDTH-1:0] debounced
);

    logic [WIDTH-1:0] accepted;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      read_word;
    logic             wr_mask;
    logic             wr_edge;
    logic             wr_cap;
    logic             unused_wdata;

    // One synchroniser/debouncer per input pin
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw      (in_raw[i]),
            .debounced(debounced[i]),
            .accepted (accepted[i])
        );
    end

    // Upper write-data bits have no register behind them
    assign wdata        = avs_writedata[WIDTH-1:0];
    assign unused_wdata = ^avs_writedata[31:WIDTH];

    assign wr_mask = avs_write && (avs_address == ADDR_MASK);
    assign wr_edge = avs_write && (avs_address == ADDR_EDGE_SEL);
    assign wr_cap  = avs_write && (avs_address == ADDR_CAPTURE);

    // An accepted change is captured when its new level matches the selected edge
    assign cap_set = accepted & ~(debounced ^ edge_sel);
    assign cap_clr = wr_cap ? wdata : '0;

    assign irq = |(capture & irq_mask);

    // Register read mux; unused bits read as zero
    always_comb begin
        read_word = '0;
        case (avs_address)
            ADDR_DATA:     read_word[WIDTH-1:0] = debounced;
            ADDR_MASK:     read_word[WIDTH-1:0] = irq_mask;
            ADDR_CAPTURE:  read_word[WIDTH-1:0] = capture;
            ADDR_EDGE_SEL: read_word[WIDTH-1:0] = edge_sel;
            default:       read_word = '0;
        endcase
    end

    // Read/write control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_mask <= '0;
            edge_sel <= '0;
        end else begin
            if (wr_mask) begin
                irq_mask <= wdata;
            end
            if (wr_edge) begin
                edge_sel <= wdata;
            end
        end
    end

    // Capture register: a new edge in the same clock as its clear keeps the bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture <= '0;
        end else begin
            capture <= (capture & ~cap_clr) | cap_set;
        end
    end

    // Read data is loaded the clock after the strobe and held until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= read_word;
        end
    end

endmodule

// File: tb/tb_key_sw_capture.sv
// Bench for key_sw_capture: directed scenarios with literal expectations plus
// randomized pin/bus traffic checked every cycle against a window-based model.
module tb_key_sw_capture;

    localparam int WIDTH = 6;
    localparam int DEB   = 4;

    logic        clk           = 1'b0;
    logic        rst_n         = 1'b1;
    logic [5:0]  in_raw        = '0;
    logic [1:0]  avs_address   = '0;
    logic        avs_read      = 1'b0;
    logic        avs_write     = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [5:0]  debounced;

    int total  = 0;
    int bad    = 0;
    bit cmp_en = 1'b0;

    key_sw_capture #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_raw       (in_raw),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .irq          (irq),
        .debounced    (debounced)
    );

    always #5 clk = ~clk;

    // Behavioural model: pins seen two clocks late, a level is accepted when
    // the last DEB synchronised samples all disagree with it
    logic [5:0]  raw_hist[$];
    logic [5:0]  win[$];
    logic [5:0]  m_deb   = '0;
    logic [5:0]  m_valid = '0;
    logic [5:0]  m_pend  = '0;
    logic [5:0]  m_mask  = '0;
    logic [5:0]  m_esel  = '0;
    logic [5:0]  m_cap   = '0;
    logic [31:0] m_rd    = '0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [5:0]  sync_v;
        logic [5:0]  toggle;
        logic [5:0]  stable;
        logic [5:0]  set_v;
        logic [5:0]  clr_v;
        logic [31:0] word;
        int          nd;
        if (!rst_n) begin
            raw_hist.delete();
            win.delete();
            m_deb   = '0;
            m_valid = '0;
            m_pend  = '0;
            m_mask  = '0;
            m_esel  = '0;
            m_cap   = '0;
            m_rd    = '0;
        end else begin
            sync_v = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 6'b0;
            raw_hist.push_back(in_raw);
            if (raw_hist.size() > 2) void'(raw_hist.pop_front());
            win.push_back(sync_v);
            if (win.size() > DEB) void'(win.pop_front());
            toggle = '0;
            stable = '0;
            if (win.size() == DEB) begin
                for (int b = 0; b < 6; b++) begin
                    nd = 0;
                    foreach (win[j]) if (win[j][b] != m_deb[b]) nd++;
                    if (nd == DEB) toggle[b] = 1'b1;
                    if (nd == 0) stable[b] = 1'b1;
                end
            end
            set_v = m_pend & ~(m_deb ^ m_esel);
            word = '0;
            case (avs_address)
                2'd0: word[5:0] = m_deb;
                2'd1: word[5:0] = m_mask;
                2'd2: word[5:0] = m_cap;
                default: word[5:0] = m_esel;
            endcase
            clr_v = '0;
            if (avs_read) m_rd = word;
            if (avs_write) begin
                case (avs_address)
                    2'd1: m_mask = avs_writedata[5:0];
                    2'd2: clr_v  = avs_writedata[5:0];
                    2'd3: m_esel = avs_writedata[5:0];
                    default: ;
                endcase
            end
            m_cap   = (m_cap & ~clr_v) | set_v;
            m_pend  = toggle & m_valid;
            m_valid = m_valid | toggle | stable;
            m_deb   = m_deb ^ toggle;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the visible outputs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("model_debounced", 32'(debounced), 32'(m_deb));
            checkOutput("model_irq", 32'(irq), 32'(|(m_cap & m_mask)));
            checkOutput("model_readdata", avs_readdata, m_rd);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(0, 5) == 0) in_raw[$urandom_range(0, 5)] ^= 1'b1;
            avs_read      = ($urandom_range(0, 3) == 0);
            avs_write     = ($urandom_range(0, 5) == 0);
            avs_address   = 2'($urandom_range(0, 3));
            avs_writedata = $urandom;
            @(negedge clk);
        end
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;

        // Power-up with two keys held high
        in_raw = 6'b000011;
        #3 rst_n = 1'b0;
        tick(2);
        cmp_en = 1'b1;
        checkOutput("reset_debounced", 32'(debounced), 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        checkOutput("reset_readdata", avs_readdata, 32'h0);
        #2 rst_n = 1'b1;
        tick(5);
        checkOutput("powerup_before", 32'(debounced), 32'h00);
        tick(1);
        checkOutput("powerup_level", 32'(debounced), 32'h03);
        tick(2);
        reg_read(2'd2, rd);
        checkOutput("powerup_capture", rd, 32'h0);

        // Three-clock glitch on bit 0
        in_raw[0] = 1'b0;
        tick(3);
        in_raw[0] = 1'b1;
        tick(10);
        checkOutput("glitch_level", 32'(debounced), 32'h03);
        reg_read(2'd2, rd);
        checkOutput("glitch_capture", rd, 32'h0);

        // Falling edge on bit 0 with its interrupt enabled
        reg_write(2'd3, 32'h00);
        reg_write(2'd1, 32'h01);
        in_raw[0] = 1'b0;
        tick(5);
        checkOutput("fall_hold", 32'(debounced), 32'h03);
        tick(1);
        checkOutput("fall_level", 32'(debounced), 32'h02);
        checkOutput("fall_irq_early", 32'(irq), 32'h0);
        tick(1);
        checkOutput("fall_irq", 32'(irq), 32'h1);
        reg_read(2'd2, rd);
        checkOutput("fall_capture", rd, 32'h01);
        reg_write(2'd2, 32'h01);
        checkOutput("fall_irq_clear", 32'(irq), 32'h0);

        // Clear of bit 2 lands in the same clock as its new rising edge
        reg_write(2'd3, 32'h04);
        in_raw[2] = 1'b1;
        tick(6);
        reg_write(2'd2, 32'h04);
        reg_read(2'd2, rd);
        checkOutput("set_beats_clear", rd, 32'h04);
        checkOutput("set_beats_clear_irq", 32'(irq), 32'h0);

        // Rising edge on bit 3 while masked, then enable
        reg_write(2'd1, 32'h00);
        reg_write(2'd3, 32'h0C);
        in_raw[3] = 1'b1;
        tick(8);
        checkOutput("masked_irq", 32'(irq), 32'h0);
        reg_read(2'd2, rd);
        checkOutput("masked_capture", rd, 32'h0C);
        reg_write(2'd1, 32'h08);
        checkOutput("unmask_irq", 32'(irq), 32'h1);
        reg_write(2'd2, 32'hFFFF_FFFF);
        checkOutput("clear_all_irq", 32'(irq), 32'h0);

        // Reset in the middle of a debounce on bit 4
        in_raw[4] = 1'b1;
        tick(2);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_debounced", 32'(debounced), 32'h0);
        checkOutput("midreset_readdata", avs_readdata, 32'h0);
        tick(1);
        #2 rst_n = 1'b1;
        tick(10);
        reg_read(2'd1, rd);
        checkOutput("post_reset_mask", rd, 32'h0);
        reg_read(2'd3, rd);
        checkOutput("post_reset_edge_sel", rd, 32'h0);
        reg_read(2'd2, rd);
        checkOutput("post_reset_capture", rd, 32'h0);
        checkOutput("post_reset_irq", 32'(irq), 32'h0);
        reg_read(2'd0, rd);
        checkOutput("post_reset_data", rd, 32'h1E);
        tick(2);
        checkOutput("readdata_hold", avs_readdata, 32'h1E);

        // Randomized traffic with one reset in between
        applyStimulus(3000);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(2000);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
